// File: rtl/acq_pkg.sv
//------------------------------------------------------------------------------
// Module  : acq_pkg
// Brief   : Shared types and constants for the acquisition-window controller.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package acq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2
    } acq_state_t;

    localparam logic [7:0] CMD_WAVE  = 8'h77;
    localparam logic [7:0] CMD_FIR   = 8'h69;
    localparam logic [7:0] CMD_ABORT = 8'h78;

    // Mode index width; a single-mode build still needs a 1-bit field.
    function automatic int mode_width(input int num_modes);
        return (num_modes > 1) ? $clog2(num_modes) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/acq_cmd_decode.sv
//------------------------------------------------------------------------------
// Module  : acq_cmd_decode
// Brief   : Combinational command-table lookup; lowest matching slot wins.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module acq_cmd_decode
    import acq_pkg::*;
#(
    parameter int                          NUM_MODES  = 2,
    parameter int                          CHAR_W     = 8,
    parameter logic [NUM_MODES*CHAR_W-1:0] MODE_CHARS = {CMD_FIR, CMD_WAVE},
    parameter logic [CHAR_W-1:0]           ABORT_CHAR = CMD_ABORT,
    parameter int                          MODE_W     = 1
) (
    input  logic [CHAR_W-1:0] i_char,
    output logic              o_match,
    output logic [MODE_W-1:0] o_index,
    output logic              o_is_abort
);

    always_comb begin
        o_match = 1'b0;
        o_index = '0;
        // Scan downwards so the lowest matching index is the one left standing.
        for (int i = NUM_MODES - 1; i >= 0; i--) begin
            if (i_char == MODE_CHARS[i*CHAR_W +: CHAR_W]) begin
                o_match = 1'b1;
                o_index = MODE_W'(i);
            end
        end
        o_is_abort = (i_char == ABORT_CHAR);
    end

endmodule

`default_nettype wire

// File: rtl/acquire_ctrl.sv
//------------------------------------------------------------------------------
// Module  : acquire_ctrl
// Brief   : UART-commanded fixed-length acquisition window with abort/status.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module acquire_ctrl
    import acq_pkg::*;
#(
    parameter int                          NUM_MODES  = 2,
    parameter int                          CHAR_W     = 8,
    parameter logic [NUM_MODES*CHAR_W-1:0] MODE_CHARS = {CMD_FIR, CMD_WAVE},
    parameter logic [CHAR_W-1:0]           ABORT_CHAR = CMD_ABORT,
    parameter int                          WINDOW_LEN = 36049,
    parameter int                          WINDOW_W   = 19,
    parameter int                          WAVENUM_W  = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [CHAR_W-1:0]                   char,
    input  logic                                newChar,
    input  logic [WAVENUM_W-1:0]                wavenum,
    output logic [NUM_MODES-1:0]                acquire,
    output logic [mode_width(NUM_MODES)-1:0]    mode,
    output logic                                busy,
    output logic                                done,
    output logic                                hit,
    output logic                                aborted,
    output logic                                errUnknown
);

    localparam int MODE_W = mode_width(NUM_MODES);
    localparam logic [WINDOW_W-1:0] C_LAST_CNT = WINDOW_W'(WINDOW_LEN - 1);

    generate
        if ((WINDOW_LEN < 2) || (64'(WINDOW_LEN) >= (64'd1 << WINDOW_W))) begin : g_param_check
            $error("acquire_ctrl: WINDOW_LEN must be >= 2 and below 2**WINDOW_W");
        end
    endgenerate

    acq_state_t            r_state, w_state_nxt;
    logic [WINDOW_W-1:0]   r_cnt, w_cnt_nxt;
    logic [WAVENUM_W-1:0]  r_last_wave, w_last_wave_nxt;
    logic [MODE_W-1:0]     r_mode, w_mode_nxt;
    logic [NUM_MODES-1:0]  r_acquire, w_acquire_nxt;
    logic                  r_busy, r_done, r_hit, r_aborted, r_err;
    logic                  w_done_nxt, w_hit_nxt, w_aborted_nxt, w_err_nxt;

    logic                  w_match;
    logic [MODE_W-1:0]     w_index;
    logic                  w_is_abort;

    acq_cmd_decode #(
        .NUM_MODES  (NUM_MODES),
        .CHAR_W     (CHAR_W),
        .MODE_CHARS (MODE_CHARS),
        .ABORT_CHAR (ABORT_CHAR),
        .MODE_W     (MODE_W)
    ) u_cmd_decode (
        .i_char     (char),
        .o_match    (w_match),
        .o_index    (w_index),
        .o_is_abort (w_is_abort)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_last_wave <= '0;
            r_mode      <= '0;
            r_acquire   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_hit       <= 1'b0;
            r_aborted   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_last_wave <= w_last_wave_nxt;
            r_mode      <= w_mode_nxt;
            r_acquire   <= w_acquire_nxt;
            r_busy      <= (w_state_nxt != IDLE);
            r_done      <= w_done_nxt;
            r_hit       <= w_hit_nxt;
            r_aborted   <= w_aborted_nxt;
            r_err       <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_last_wave_nxt = r_last_wave;
        w_mode_nxt      = r_mode;
        w_acquire_nxt   = r_acquire;
        w_done_nxt      = 1'b0;
        w_hit_nxt       = 1'b0;
        w_aborted_nxt   = 1'b0;
        w_err_nxt       = 1'b0;

        case (r_state)
            IDLE: begin
                if (newChar) begin
                    if (w_match) begin
                        w_state_nxt   = ARMED;
                        w_cnt_nxt     = '0;
                        w_mode_nxt    = w_index;
                        w_acquire_nxt = '0;
                    end else if (!w_is_abort) begin
                        w_err_nxt = 1'b1;
                    end
                end
            end

            ARMED, ACTIVE: begin
                // Abort outranks the window end; other commands are dropped.
                if (newChar && w_is_abort) begin
                    w_state_nxt   = IDLE;
                    w_acquire_nxt = '0;
                    w_aborted_nxt = 1'b1;
                end else if (r_cnt == C_LAST_CNT) begin
                    w_state_nxt     = IDLE;
                    w_acquire_nxt   = '0;
                    w_done_nxt      = 1'b1;
                    w_hit_nxt       = (r_state == ACTIVE);
                    w_last_wave_nxt = wavenum;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if ((r_state == ARMED) && (wavenum != r_last_wave)) begin
                        w_state_nxt   = ACTIVE;
                        w_acquire_nxt = NUM_MODES'(1) << r_mode;
                    end
                end
            end

            default: begin
                w_state_nxt   = IDLE;
                w_acquire_nxt = '0;
            end
        endcase
    end

    assign acquire    = r_acquire;
    assign mode       = r_mode;
    assign busy       = r_busy;
    assign done       = r_done;
    assign hit        = r_hit;
    assign aborted    = r_aborted;
    assign errUnknown = r_err;

endmodule

`default_nettype wire

// File: tb/tb_acquire_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_acquire_ctrl
// Brief   : Directed self-checking bench for acquire_ctrl (2-mode and 4-mode).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_acquire_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  char_in = 8'h00;
    logic        newChar = 1'b0;
    logic [7:0]  char4 = 8'h00;
    logic        newChar4 = 1'b0;
    logic [15:0] wavenum = 16'd0;

    logic [1:0]  acquire;
    logic        mode;
    logic        busy, done, hit, aborted, errUnknown;

    logic [3:0]  acquire4;
    logic [1:0]  mode4;
    logic        busy4, done4, hit4, aborted4, err4;

    int checks = 0;
    int failures = 0;
    int busy_len = 0;

    always #5 clk = ~clk;

    acquire_ctrl #(
        .NUM_MODES  (2),
        .CHAR_W     (8),
        .MODE_CHARS (16'h6977),
        .ABORT_CHAR (8'h78),
        .WINDOW_LEN (16),
        .WINDOW_W   (5),
        .WAVENUM_W  (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .char       (char_in),
        .newChar    (newChar),
        .wavenum    (wavenum),
        .acquire    (acquire),
        .mode       (mode),
        .busy       (busy),
        .done       (done),
        .hit        (hit),
        .aborted    (aborted),
        .errUnknown (errUnknown)
    );

    acquire_ctrl #(
        .NUM_MODES  (4),
        .CHAR_W     (8),
        .MODE_CHARS ({"d", "c", "b", "a"}),
        .ABORT_CHAR (8'h78),
        .WINDOW_LEN (8),
        .WINDOW_W   (4),
        .WAVENUM_W  (16)
    ) dut4 (
        .clk        (clk),
        .rst        (rst),
        .char       (char4),
        .newChar    (newChar4),
        .wavenum    (wavenum),
        .acquire    (acquire4),
        .mode       (mode4),
        .busy       (busy4),
        .done       (done4),
        .hit        (hit4),
        .aborted    (aborted4),
        .errUnknown (err4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and sample 1ns later; tallies cycles with busy high.
    task automatic step();
        @(posedge clk);
        #1;
        if (busy) busy_len++;
    endtask

    task automatic cmd(input logic [7:0] c);
        char_in = c;
        newChar = 1'b1;
        step();
        newChar = 1'b0;
    endtask

    task automatic open(input logic [7:0] c);
        busy_len = 0;
        cmd(c);
    endtask

    task automatic run_to_close(input logic [1:0] acq_exp, input logic hit_exp);
        int n = 0;
        while (busy && n < 64) begin
            chk("acq_in_window", 32'(acquire), 32'(acq_exp));
            step();
            n++;
        end
        chk("close_busy", 32'(busy), 32'd0);
        chk("close_done", 32'(done), 32'd1);
        chk("close_hit", 32'(hit), 32'(hit_exp));
        chk("close_acq", 32'(acquire), 32'd0);
        chk("window_len", 32'(busy_len), 32'd16);
        step();
        chk("done_pulse", 32'(done), 32'd0);
        chk("hit_pulse", 32'(hit), 32'd0);
    endtask

    initial begin
        wavenum = 16'd5;
        step();
        step();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_acq", 32'(acquire), 32'd0);
        chk("rst_mode", 32'(mode), 32'd0);
        chk("rst_flags", {28'd0, done, hit, aborted, errUnknown}, 32'd0);
        chk("rst_busy4", 32'(busy4), 32'd0);

        // Window 1: lastWave=0, wavenum=5 -> acquire from T+1.
        open(8'h77);
        chk("w1_busy", 32'(busy), 32'd1);
        chk("w1_acq_T", 32'(acquire), 32'd0);
        chk("w1_mode", 32'(mode), 32'd0);
        step();
        chk("w1_acq_T1", 32'(acquire), 32'd1);
        run_to_close(2'b01, 1'b1);

        // Window 2: wavenum still 5; changes to 6 during cycle T+3.
        open(8'h77);
        for (int i = 0; i < 3; i++) begin
            chk("w2_acq_idle", 32'(acquire), 32'd0);
            step();
        end
        chk("w2_acq_T3", 32'(acquire), 32'd0);
        wavenum = 16'd6;
        step();
        chk("w2_acq_T4", 32'(acquire), 32'd1);
        run_to_close(2'b01, 1'b1);

        // Window 3: 'i' with wavenum unchanged; 'w' mid-window is dropped.
        open(8'h69);
        chk("w3_mode", 32'(mode), 32'd1);
        step();
        step();
        cmd(8'h77);
        chk("w3_drop_mode", 32'(mode), 32'd1);
        chk("w3_drop_err", 32'(errUnknown), 32'd0);
        chk("w3_drop_busy", 32'(busy), 32'd1);
        run_to_close(2'b00, 1'b0);
        chk("w3_mode_after", 32'(mode), 32'd1);

        // Unknown and idle-abort characters.
        cmd(8'h41);
        chk("err_pulse", 32'(errUnknown), 32'd1);
        chk("err_busy", 32'(busy), 32'd0);
        step();
        chk("err_clear", 32'(errUnknown), 32'd0);
        cmd(8'h78);
        chk("idle_abort_ab", 32'(aborted), 32'd0);
        chk("idle_abort_err", 32'(errUnknown), 32'd0);
        chk("idle_abort_busy", 32'(busy), 32'd0);

        // Abort at window cycle 8.
        open(8'h69);
        wavenum = 16'd7;
        step();
        chk("ab_acq", 32'(acquire), 32'd2);
        repeat (6) step();
        cmd(8'h78);
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_acq_clr", 32'(acquire), 32'd0);
        chk("ab_pulse", 32'(aborted), 32'd1);
        chk("ab_no_done", 32'(done), 32'd0);
        step();
        chk("ab_pulse_end", 32'(aborted), 32'd0);
        chk("ab_no_done2", 32'(done), 32'd0);

        // lastWave still 6, so wavenum=7 arms immediately; abort in final cycle.
        open(8'h77);
        chk("fa_acq_T", 32'(acquire), 32'd0);
        step();
        chk("fa_acq_T1", 32'(acquire), 32'd1);
        repeat (14) step();
        chk("fa_busy_T15", 32'(busy), 32'd1);
        cmd(8'h78);
        chk("fa_aborted", 32'(aborted), 32'd1);
        chk("fa_no_done", 32'(done), 32'd0);
        chk("fa_busy", 32'(busy), 32'd0);
        chk("fa_hit", 32'(hit), 32'd0);
        step();

        // Mode command in final cycle is dropped; window closes normally.
        open(8'h77);
        step();
        chk("fm_acq_T1", 32'(acquire), 32'd1);
        repeat (14) step();
        cmd(8'h69);
        chk("fm_done", 32'(done), 32'd1);
        chk("fm_hit", 32'(hit), 32'd1);
        chk("fm_busy", 32'(busy), 32'd0);
        chk("fm_mode", 32'(mode), 32'd0);
        chk("fm_len", 32'(busy_len), 32'd16);
        step();
        chk("fm_no_reopen", 32'(busy), 32'd0);

        // Reset mid-ACTIVE clears everything including lastWave.
        open(8'h69);
        wavenum = 16'd8;
        step();
        chk("rs_acq", 32'(acquire), 32'd2);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rs_busy", 32'(busy), 32'd0);
        chk("rs_acq_clr", 32'(acquire), 32'd0);
        chk("rs_mode", 32'(mode), 32'd0);
        chk("rs_flags", {28'd0, done, hit, aborted, errUnknown}, 32'd0);
        wavenum = 16'd0;
        open(8'h77);
        run_to_close(2'b00, 1'b0);

        // Four-mode instance: each command raises its own acquire bit.
        for (int j = 0; j < 4; j++) begin
            int n;
            wavenum  = 16'(100 + j);
            char4    = 8'(8'h61 + j);
            newChar4 = 1'b1;
            step();
            newChar4 = 1'b0;
            chk("m4_busy", 32'(busy4), 32'd1);
            chk("m4_mode", 32'(mode4), 32'(j));
            step();
            chk("m4_acq", 32'(acquire4), 32'(4'b0001 << j));
            n = 0;
            while (busy4 && n < 32) begin
                step();
                n++;
            end
            chk("m4_done", 32'(done4), 32'd1);
            chk("m4_hit", 32'(hit4), 32'd1);
            chk("m4_acq_clr", 32'(acquire4), 32'd0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/acquire_ctrl.md
# acquire_ctrl

Parametrised acquisition-window controller between the UART receiver and the ADC waveform/FIR capture paths. A one-byte UART command selects one of `NUM_MODES` capture modes and opens a fixed-length window of `WINDOW_LEN` clocks. Inside that window, the selected mode's acquire line is held from the first cycle the waveform counter moves past the number stored at the previous window close until the window ends. It adds an abort command, busy/done/hit status and an unknown-command flag.

## Interface
- `NUM_MODES`, 2: number of capture modes (acquire lines).
- `CHAR_W`, 8: command character width.
- `MODE_CHARS`, {8'h69, 8'h77}: packed `NUM_MODES*CHAR_W` command table; slice i is the command for mode i (mode0 'w' = wave, mode1 'i' = wave+FIR).
- `ABORT_CHAR`, 8'h78: 'x', closes an open window early.
- `WINDOW_LEN`, 36049: window length in clocks; ≥2.
- `WINDOW_W`, 19: counter width; 2^WINDOW_W > WINDOW_LEN.
- `WAVENUM_W`, 16: waveform-number width.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `char` in CHAR_W: last received UART byte.
- `newChar` in 1: one-cycle strobe, `char` valid.
- `wavenum` in WAVENUM_W: current waveform number from capture logic.
- `acquire` out NUM_MODES: one-hot acquire lines; bit i = mode i.
- `mode` out clog2(NUM_MODES): mode of current/last window.
- `busy` out 1: window open.
- `done` out 1: one-cycle pulse at normal window close.
- `hit` out 1: valid with `done`; 1 if acquire was asserted during the window.
- `aborted` out 1: one-cycle pulse on abort.
- `errUnknown` out 1: one-cycle pulse, unrecognised command in IDLE.

## Operation
- States: IDLE, ARMED, ACTIVE.
- Internal registers:
  - `cnt` (WINDOW_W): window cycle counter.
  - `lastWave` (WAVENUM_W): waveform number stored at the previous normal window close.
- IDLE, `newChar`=1:
  - `char` matches slice i of `MODE_CHARS`: latch `mode`←i, `cnt`←0, go ARMED.
  - Multiple matches: lowest i wins.
  - `char`==`ABORT_CHAR` in IDLE: ignored, no pulse.
  - Any other `char`: pulse `errUnknown`, stay IDLE.
- ARMED:
  - `cnt` increments each cycle.
  - If `wavenum`≠`lastWave`: go ACTIVE and set `acquire[mode]`.
- ACTIVE: `cnt` increments; `acquire[mode]` holds. Later `wavenum` changes are ignored.
- Window end, ARMED or ACTIVE with `cnt`==WINDOW_LEN−1:
  - go IDLE; clear `acquire`; pulse `done`.
  - `hit` = (state was ACTIVE).
  - `lastWave`←`wavenum`.
- Abort, ARMED or ACTIVE with `newChar`=1 and `char`==`ABORT_CHAR`:
  - go IDLE; clear `acquire`; pulse `aborted`.
  - No `done`; `lastWave` is not updated.
- Any other `newChar` while busy is dropped silently.
- `busy` = state≠IDLE, registered.
- At most one `acquire` bit is ever high.
- Reset (any state, mid-window included): state IDLE, `cnt`=0, `lastWave`=0, `mode`=0. At next edge, all outputs 0.

## Timing
- All outputs are registered.
- Command accepted at edge T (`newChar` high in cycle T−1): `busy`=1 from T.
- ARMED→ACTIVE: `wavenum` differs in cycle k → `acquire` high from edge k+1.
- Already differing when ARMED is entered: `acquire` high at T+1.
- Window length: `busy` is high for exactly WINDOW_LEN cycles unless aborted. `done`, `hit` and `busy`/`acquire` falling all occur at the same edge.
- Earliest next command is the cycle `busy` is low: back-to-back windows have a 1-cycle gap minimum.
- Simultaneous events:
  - Abort in the final window cycle: abort wins, no `done`.
  - Mode command in the final cycle: dropped.
  - `rst` with any event: reset wins.
- `cnt` never wraps; WINDOW_W is sized so WINDOW_LEN−1 fits.

## Structure
- Package `acq_pkg`:
  - state enum {IDLE, ARMED, ACTIVE};
  - default command constants CMD_WAVE=8'h77, CMD_FIR=8'h69, CMD_ABORT=8'h78.
- Sub-module `acq_cmd_decode`: pure combinational table match (`char`, `MODE_CHARS`) → {match, index, isAbort}. Instantiated once.
- Top holds the FSM, counter, `lastWave` and output registers.
- Elaboration check: WINDOW_LEN<2^WINDOW_W and WINDOW_LEN≥2; fail otherwise.

## Test plan
- Defaults: reset, `wavenum`=5, `newChar` with 8'h77 → `busy` for 36049 cycles; `acquire`=2'b01 from T+1; `done`=1, `hit`=1 at close; `lastWave`=5.
- Second 'w' with `wavenum` still 5 → `acquire` stays 0 for the whole window. Set `wavenum`=6 at window cycle 100 → `acquire`=2'b01 from cycle 101 to the end.
- WINDOW_LEN=16: 'i' with `wavenum` never changing → `acquire`=0 throughout; `done`=1, `hit`=0 after 16 cycles; `errUnknown` for 8'h41 in IDLE; 8'h77 while busy is ignored.
- Abort: 'i' then `wavenum` change, then 8'h78 at cycle 8 → `acquire` and `busy` drop next edge; `aborted`=1; no `done`; `lastWave` unchanged.
- Corner: 8'h78 in the final window cycle → `aborted` only. `rst` mid-ACTIVE → all outputs 0 next edge, `lastWave`=0.
- NUM_MODES=4, MODE_CHARS={"d","c","b","a"}: each character raises the matching single bit of `acquire`; `mode` reports 0–3.
